// File: rtl/pico_io_bridge.sv
// KCPSM6 I/O bridge: port decode, stretched write strobes, registered read mux, edge-interrupt aggregation.
// Build option PICO_IRQ_MASK_EN: adds a writable interrupt mask at SYS_CH dir 1 (otherwise mask is all ones).
module pico_io_bridge #(
  parameter int N_CH    = 4,
  parameter int STRETCH = 2,
  parameter int SYS_CH  = 15
) (
  input  logic              clk_i,
  input  logic              kcpsm6_reset_i,
  input  logic [7:0]        port_id_i,
  input  logic [7:0]        out_port_i,
  input  logic              write_strobe_i,
  input  logic              k_write_strobe_i,
  input  logic              read_strobe_i,
  output logic [7:0]        in_port_o,
  output logic              interrupt_o,
  input  logic              interrupt_ack_i,
  input  logic [8*N_CH-1:0] ch_rd_data_i,
  input  logic [N_CH-1:0]   ch_irq_i,
  output logic [N_CH-1:0]   ch_wr_o,
  output logic [N_CH-1:0]   ch_rd_o,
  output logic [7:0]        ch_wdata_o,
  output logic [7:0]        dir_o
);

  localparam logic [3:0] NCH_L  = 4'(N_CH);
  localparam logic [3:0] SYS_L  = 4'(SYS_CH);
  localparam logic [3:0] LOAD_L = 4'(STRETCH - 1);

  logic [N_CH-1:0] ch_wr_q, ch_wr_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [N_CH-1:0] ch_rd_q, ch_rd_d;
  logic [7:0]      wdata_q, wdata_d;
  logic [3:0]      dir_q, dir_d;
  logic [7:0]      in_port_q, in_port_d;
  logic            irq_q, irq_d;
  logic [N_CH-1:0] pending_q, pending_d;
  logic [N_CH-1:0] irq_dly_q;
  logic [2:0]      last_id_q, last_id_d;

  logic [N_CH-1:0] mask_v;
  logic [7:0]      mask_rd;
`ifdef PICO_IRQ_MASK_EN
  logic [N_CH-1:0] mask_q, mask_d;
  assign mask_v  = mask_q;
  assign mask_rd = 8'(mask_q);
`else
  assign mask_v  = '1;
  assign mask_rd = 8'hFF;
`endif

  logic            wr_any;
  logic [3:0]      wr_c;
  logic [3:0]      wr_dir;
  logic [3:0]      rd_c;
  logic [3:0]      dir_lo;
  logic [N_CH-1:0] edge_v;
  logic [N_CH-1:0] pm;
  logic [N_CH-1:0] clr_v;
  logic [2:0]      ack_idx;
  logic            found;

  function automatic logic [N_CH-1:0] onehot(input logic [3:0] c);
    logic [N_CH-1:0] r;
    r = '0;
    for (int i = 0; i < N_CH; i++)
      if (c == 4'(i)) r[i] = 1'b1;
    return r;
  endfunction

  // OUTPUTK carries the channel in the low nibble and has no direction field
  assign wr_any = write_strobe_i | k_write_strobe_i;
  assign wr_c   = write_strobe_i ? port_id_i[7:4] : port_id_i[3:0];
  assign wr_dir = write_strobe_i ? port_id_i[3:0] : 4'h0;
  assign rd_c   = port_id_i[7:4];
  assign dir_lo = port_id_i[3:0];

  always_comb begin
    ch_wr_d = ch_wr_q;
    cnt_d   = cnt_q;
    ch_rd_d = '0;
    wdata_d = wdata_q;
    dir_d   = dir_q;
    if (cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;
    else               ch_wr_d = '0;
    if (read_strobe_i && rd_c < NCH_L) begin
      ch_rd_d = onehot(rd_c);
      dir_d   = dir_lo;
    end
    if (wr_any && wr_c < NCH_L) begin
      ch_wr_d = onehot(wr_c);
      cnt_d   = LOAD_L;
      wdata_d = out_port_i;
      dir_d   = wr_dir;
    end else if (wr_any && wr_c == SYS_L) begin
      wdata_d = out_port_i;
      dir_d   = wr_dir;
    end
  end

  always_comb begin
    in_port_d = 8'h00;
    if (rd_c < NCH_L) begin
      for (int i = 0; i < N_CH; i++)
        if (rd_c == 4'(i)) in_port_d = ch_rd_data_i[8*i +: 8];
    end else if (rd_c == SYS_L) begin
      case (dir_lo)
        4'd0:    in_port_d = 8'(pending_q);
        4'd1:    in_port_d = mask_rd;
        4'd2:    in_port_d = {5'b0, last_id_q};
        default: in_port_d = 8'h00;
      endcase
    end
  end

  // An ack retires the lowest-index unmasked pending bit; a fresh edge on that bit wins
  always_comb begin
    edge_v  = ch_irq_i & ~irq_dly_q;
    pm      = pending_q & mask_v;
    clr_v   = '0;
    ack_idx = 3'd0;
    found   = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      if (!found && pm[i]) begin
        found    = 1'b1;
        clr_v[i] = 1'b1;
        ack_idx  = 3'(i);
      end
    end
    pending_d = pending_q;
    last_id_d = last_id_q;
    if (interrupt_ack_i && found) begin
      pending_d = pending_q & ~clr_v;
      last_id_d = ack_idx;
    end
    pending_d = pending_d | edge_v;
    irq_d     = |pm;
  end

`ifdef PICO_IRQ_MASK_EN
  always_comb begin
    mask_d = mask_q;
    if (write_strobe_i && rd_c == SYS_L && dir_lo == 4'd1)
      mask_d = out_port_i[N_CH-1:0];
  end
`endif

  always_ff @(posedge clk_i or posedge kcpsm6_reset_i) begin
    if (kcpsm6_reset_i) begin
      ch_wr_q   <= '0;
      cnt_q     <= 4'd0;
      ch_rd_q   <= '0;
      wdata_q   <= 8'h00;
      dir_q     <= 4'h0;
      in_port_q <= 8'h00;
      irq_q     <= 1'b0;
      pending_q <= '0;
      irq_dly_q <= '0;
      last_id_q <= 3'd0;
`ifdef PICO_IRQ_MASK_EN
      mask_q    <= '1;
`endif
    end else begin
      ch_wr_q   <= ch_wr_d;
      cnt_q     <= cnt_d;
      ch_rd_q   <= ch_rd_d;
      wdata_q   <= wdata_d;
      dir_q     <= dir_d;
      in_port_q <= in_port_d;
      irq_q     <= irq_d;
      pending_q <= pending_d;
      irq_dly_q <= ch_irq_i;
      last_id_q <= last_id_d;
`ifdef PICO_IRQ_MASK_EN
      mask_q    <= mask_d;
`endif
    end
  end

  assign ch_wr_o     = ch_wr_q;
  assign ch_rd_o     = ch_rd_q;
  assign ch_wdata_o  = wdata_q;
  assign dir_o       = {4'h0, dir_q};
  assign in_port_o   = in_port_q;
  assign interrupt_o = irq_q;

endmodule
